// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the parametrised register file.
// Imported by the interface, the busy scoreboard and the top.
package regfile_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 4;

    localparam int unsigned ZERO_ADDR = 0;

    // An address is writable/reservable unless it is the hard-wired zero register.
    function automatic logic is_writable(input int unsigned addr, input logic zero_reg);
        return !(zero_reg && (addr == ZERO_ADDR));
    endfunction

endpackage

// File: rtl/regfile_if.sv
// Decode/writeback-facing bus of the register file: two read ports,
// one write port, a reservation port and the busy scoreboard status.
interface regfile_if
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);

    logic [ADDR_WIDTH-1:0] read_register1;
    logic [ADDR_WIDTH-1:0] read_register2;
    logic [DATA_WIDTH-1:0] read_data1;
    logic [DATA_WIDTH-1:0] read_data2;
    logic                  read_busy1;
    logic                  read_busy2;

    logic                  reg_write;
    logic [ADDR_WIDTH-1:0] write_register;
    logic [DATA_WIDTH-1:0] write_data;

    logic                  reserve_en;
    logic [ADDR_WIDTH-1:0] reserve_register;
    logic                  flush;

    logic [ADDR_WIDTH:0]   busy_count;

    modport master (
        output read_register1, read_register2,
        input  read_data1, read_data2, read_busy1, read_busy2,
        output reg_write, write_register, write_data,
        output reserve_en, reserve_register, flush,
        input  busy_count
    );

    modport slave (
        input  read_register1, read_register2,
        output read_data1, read_data2, read_busy1, read_busy2,
        input  reg_write, write_register, write_data,
        input  reserve_en, reserve_register, flush,
        output busy_count
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: flush beats write/reserve, reserve beats write on
// the same address. busy_count is the popcount of the updated vector.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int ZERO_REG   = 1,
    localparam int NUM_REGS  = 2**ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic                  reserve_en,
    input  logic [ADDR_WIDTH-1:0] reserve_addr,
    input  logic                  flush,
    output logic [NUM_REGS-1:0]   busy,
    output logic [ADDR_WIDTH:0]   busy_count
);

    localparam logic ZERO_EN = (ZERO_REG != 0);

    logic                  wr_ok;
    logic                  rsv_ok;
    logic [NUM_REGS-1:0]   busy_next;
    logic [ADDR_WIDTH:0]   count_next;

    assign wr_ok  = write_en   && is_writable(32'(write_addr),   ZERO_EN);
    assign rsv_ok = reserve_en && is_writable(32'(reserve_addr), ZERO_EN);

    // Reserve is applied after the write clear so a same-address pair ends busy.
    always_comb begin
        busy_next = busy;
        if (flush) begin
            busy_next = '0;
        end else begin
            if (wr_ok)  busy_next[write_addr]   = 1'b0;
            if (rsv_ok) busy_next[reserve_addr] = 1'b1;
        end
    end

    always_comb begin
        count_next = '0;
        for (int i = 0; i < NUM_REGS; i++)
            count_next = count_next + {{ADDR_WIDTH{1'b0}}, busy_next[i]};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy       <= busy_next;
            busy_count <= count_next;
        end
    end

endmodule

// File: rtl/regfile_param.sv
// Parametrised GPR file: two combinational read ports, one write port,
// optional zero register and write-to-read bypass, plus busy scoreboard.
module regfile_param
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input logic       clock,
    input logic       reset_n,
    regfile_if.slave  bus
);

    localparam int   NUM_REGS  = 2**ADDR_WIDTH;
    localparam logic ZERO_EN   = (ZERO_REG != 0);
    localparam logic BYPASS_EN = (BYPASS != 0);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   busy;
    logic                  wr_ok;

    assign wr_ok = bus.reg_write && is_writable(32'(bus.write_register), ZERO_EN);

    // Reset clears the whole array, so an in-flight write in that cycle is lost.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (wr_ok) begin
            regs[bus.write_register] <= bus.write_data;
        end
    end

    regfile_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ZERO_REG   (ZERO_REG)
    ) u_scoreboard (
        .clock        (clock),
        .reset_n      (reset_n),
        .write_en     (bus.reg_write),
        .write_addr   (bus.write_register),
        .reserve_en   (bus.reserve_en),
        .reserve_addr (bus.reserve_register),
        .flush        (bus.flush),
        .busy         (busy),
        .busy_count   (bus.busy_count)
    );

    logic [1:0][ADDR_WIDTH-1:0] raddr;

    assign raddr[0] = bus.read_register1;
    assign raddr[1] = bus.read_register2;

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [DATA_WIDTH-1:0] data;
        logic                  bsy;
        logic                  hit;

        // Bypass is masked by reset so held reset reads zero everywhere.
        assign hit = BYPASS_EN && reset_n && wr_ok && (bus.write_register == raddr[p]);

        always_comb begin
            data = regs[raddr[p]];
            bsy  = busy[raddr[p]];
            if (hit) begin
                data = bus.write_data;
                bsy  = 1'b0;
            end
            if (!is_writable(32'(raddr[p]), ZERO_EN)) begin
                data = '0;
                bsy  = 1'b0;
            end
        end
    end

    assign bus.read_data1 = g_port[0].data;
    assign bus.read_busy1 = g_port[0].bsy;
    assign bus.read_data2 = g_port[1].data;
    assign bus.read_busy2 = g_port[1].bsy;

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: three parameter sets driven with shared stimulus,
// per-instance reference model feeding an expectation queue.
module tb_regfile_param;

    localparam int NI = 3;
    localparam int DW [NI] = '{32, 16, 64};
    localparam int AW [NI] = '{4, 3, 5};
    localparam int ZR [NI] = '{1, 0, 1};
    localparam int BP [NI] = '{1, 0, 0};

    localparam int K_RD1 = 0, K_RD2 = 1, K_B1 = 2, K_B2 = 3, K_CNT = 4;

    typedef struct {
        int          inst;
        int          kind;
        logic [63:0] val;
        string       tag;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    logic [4:0]  rr1, rr2, wa, ra;
    logic [63:0] wd;
    logic        we, re, fl;

    regfile_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) if_a ();
    regfile_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) if_b ();
    regfile_if #(.DATA_WIDTH(64), .ADDR_WIDTH(5)) if_c ();

    assign if_a.read_register1 = rr1[3:0];
    assign if_a.read_register2 = rr2[3:0];
    assign if_a.reg_write = we;
    assign if_a.write_register = wa[3:0];
    assign if_a.write_data = wd[31:0];
    assign if_a.reserve_en = re;
    assign if_a.reserve_register = ra[3:0];
    assign if_a.flush = fl;

    assign if_b.read_register1 = rr1[2:0];
    assign if_b.read_register2 = rr2[2:0];
    assign if_b.reg_write = we;
    assign if_b.write_register = wa[2:0];
    assign if_b.write_data = wd[15:0];
    assign if_b.reserve_en = re;
    assign if_b.reserve_register = ra[2:0];
    assign if_b.flush = fl;

    assign if_c.read_register1 = rr1;
    assign if_c.read_register2 = rr2;
    assign if_c.reg_write = we;
    assign if_c.write_register = wa;
    assign if_c.write_data = wd;
    assign if_c.reserve_en = re;
    assign if_c.reserve_register = ra;
    assign if_c.flush = fl;

    regfile_param #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .ZERO_REG(1), .BYPASS(1))
        dut_a (.clock(clock), .reset_n(reset_n), .bus(if_a));
    regfile_param #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .ZERO_REG(0), .BYPASS(0))
        dut_b (.clock(clock), .reset_n(reset_n), .bus(if_b));
    regfile_param #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .ZERO_REG(1), .BYPASS(0))
        dut_c (.clock(clock), .reset_n(reset_n), .bus(if_c));

    logic [63:0] m_regs [NI][32];
    logic        m_busy [NI][32];
    exp_t        q [$];
    int          n_checks = 0;
    int          n_fail = 0;

    function automatic logic [4:0] amask(int i);
        return 5'((32'd1 << AW[i]) - 1);
    endfunction

    function automatic logic [63:0] dmask(int i, logic [63:0] v);
        logic [63:0] m;
        m = (DW[i] >= 64) ? '1 : ((64'd1 << DW[i]) - 64'd1);
        return v & m;
    endfunction

    function automatic bit m_writable(int i, logic [4:0] a);
        return !(ZR[i] != 0 && a == 5'd0);
    endfunction

    function automatic logic [63:0] m_read(int i, logic [4:0] rr, bit want_data);
        logic [4:0] a, w;
        a = rr & amask(i);
        w = wa & amask(i);
        if (!reset_n) return '0;
        if (!m_writable(i, a)) return '0;
        if (BP[i] != 0 && we && m_writable(i, w) && w == a)
            return want_data ? dmask(i, wd) : 64'd0;
        return want_data ? m_regs[i][a] : 64'(m_busy[i][a]);
    endfunction

    function automatic int m_pop(int i);
        int c = 0;
        for (int r = 0; r < 32; r++) c += int'(m_busy[i][r]);
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++)
            for (int r = 0; r < 32; r++) begin
                m_regs[i][r] = '0;
                m_busy[i][r] = 1'b0;
            end
    endtask

    task automatic model_update();
        logic [4:0] w, s;
        for (int i = 0; i < NI; i++) begin
            w = wa & amask(i);
            s = ra & amask(i);
            if (we && m_writable(i, w)) m_regs[i][w] = dmask(i, wd);
            if (fl) begin
                for (int r = 0; r < 32; r++) m_busy[i][r] = 1'b0;
            end else begin
                if (we && m_writable(i, w)) m_busy[i][w] = 1'b0;
                if (re && m_writable(i, s)) m_busy[i][s] = 1'b1;
            end
        end
    endtask

    function automatic logic [63:0] act(int i, int k);
        logic [63:0] r;
        r = '0;
        case (i)
            0: case (k)
                K_RD1: r = 64'(if_a.read_data1);
                K_RD2: r = 64'(if_a.read_data2);
                K_B1:  r = 64'(if_a.read_busy1);
                K_B2:  r = 64'(if_a.read_busy2);
                default: r = 64'(if_a.busy_count);
            endcase
            1: case (k)
                K_RD1: r = 64'(if_b.read_data1);
                K_RD2: r = 64'(if_b.read_data2);
                K_B1:  r = 64'(if_b.read_busy1);
                K_B2:  r = 64'(if_b.read_busy2);
                default: r = 64'(if_b.busy_count);
            endcase
            default: case (k)
                K_RD1: r = 64'(if_c.read_data1);
                K_RD2: r = 64'(if_c.read_data2);
                K_B1:  r = 64'(if_c.read_busy1);
                K_B2:  r = 64'(if_c.read_busy2);
                default: r = 64'(if_c.busy_count);
            endcase
        endcase
        return r;
    endfunction

    task automatic push(int i, int k, logic [63:0] v, string tag);
        exp_t e;
        e.inst = i; e.kind = k; e.val = v; e.tag = tag;
        q.push_back(e);
    endtask

    // Inputs are set at the falling edge before this is called.
    task automatic step();
        exp_t        e;
        logic [63:0] a;
        if (!reset_n) model_reset();
        for (int i = 0; i < NI; i++) begin
            push(i, K_RD1, m_read(i, rr1, 1'b1), "model_rd1");
            push(i, K_RD2, m_read(i, rr2, 1'b1), "model_rd2");
            push(i, K_B1,  m_read(i, rr1, 1'b0), "model_busy1");
            push(i, K_B2,  m_read(i, rr2, 1'b0), "model_busy2");
            push(i, K_CNT, 64'(m_pop(i)), "model_count");
        end
        #1;
        while (q.size() > 0) begin
            e = q.pop_front();
            a = act(e.inst, e.kind);
            n_checks++;
            if (a !== e.val) begin
                n_fail++;
                $display("FAIL %s dut%0d kind%0d @%0t: got %h expected %h",
                         e.tag, e.inst, e.kind, $time, a, e.val);
            end
        end
        @(posedge clock);
        if (reset_n) model_update(); else model_reset();
        @(negedge clock);
    endtask

    task automatic idle();
        we = 1'b0; re = 1'b0; fl = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle();
        for (int i = 0; i < 32; i++) begin
            rr1 = 5'(i);
            rr2 = 5'(31 - i);
            push(0, K_RD1, 64'd0, "reset_rd1");
            push(0, K_CNT, 64'd0, "reset_count");
            step();
        end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_bypass();
        idle();
        we = 1'b1; wa = 5'd3; wd = 64'hDEADBEEF; rr1 = 5'd3; rr2 = 5'd3;
        push(0, K_RD1, 64'hDEADBEEF, "bypass_same_cycle");
        push(1, K_RD1, 64'h0, "nobypass_old_value");
        step();
        idle();
        push(1, K_RD1, 64'hBEEF, "nobypass_next_cycle");
        push(2, K_RD1, 64'hDEADBEEF, "nobypass_next_cycle_64");
        step();
    endtask

    task automatic test_zero_reg();
        idle();
        we = 1'b1; wa = 5'd0; wd = 64'h1234; re = 1'b1; ra = 5'd0;
        rr1 = 5'd0; rr2 = 5'd0;
        step();
        idle();
        push(0, K_RD1, 64'h0, "zero_reg_data");
        push(0, K_B1, 64'h0, "zero_reg_busy");
        push(0, K_CNT, 64'h0, "zero_reg_count");
        push(1, K_RD1, 64'h1234, "reg0_plain_data");
        push(1, K_B1, 64'h1, "reg0_plain_busy");
        step();
    endtask

    task automatic test_reserve_write();
        idle();
        re = 1'b1; ra = 5'd7; rr1 = 5'd7;
        step();
        idle();
        push(0, K_B1, 64'h1, "reserve_busy");
        push(0, K_CNT, 64'd1, "reserve_count");
        step();
        we = 1'b1; wa = 5'd7; wd = 64'hA5;
        step();
        idle();
        push(0, K_RD1, 64'hA5, "write_clear_data");
        push(0, K_B1, 64'h0, "write_clear_busy");
        push(0, K_CNT, 64'd0, "write_clear_count");
        step();
    endtask

    task automatic test_same_cycle_flush();
        idle();
        we = 1'b1; wa = 5'd9; wd = 64'h0BADF00D; re = 1'b1; ra = 5'd9; rr1 = 5'd9;
        step();
        idle();
        push(0, K_B1, 64'h1, "write_reserve_busy");
        push(0, K_RD1, 64'h0BADF00D, "write_reserve_data");
        step();
        foreach (ra[k]) begin end
        for (int k = 0; k < 3; k++) begin
            idle();
            re = 1'b1; ra = 5'(1 << k);
            step();
        end
        idle();
        fl = 1'b1; re = 1'b1; ra = 5'd6; rr1 = 5'd6; rr2 = 5'd2;
        step();
        idle();
        push(0, K_CNT, 64'd0, "flush_count");
        push(0, K_B1, 64'h0, "flush_reserve_dropped");
        push(0, K_B2, 64'h0, "flush_busy2");
        push(0, K_RD1, 64'h0, "flush_keeps_data");
        step();
    endtask

    task automatic test_random();
        reset_n = 1'b1;
        for (int n = 0; n < 400; n++) begin
            rr1 = 5'($urandom); rr2 = 5'($urandom);
            wa  = 5'($urandom); ra  = 5'($urandom);
            wd  = {$urandom, $urandom};
            we  = 1'($urandom); re = 1'($urandom);
            fl  = ($urandom_range(0, 15) == 0);
            step();
        end
        idle();
        step();
    endtask

    task automatic test_reset_midrun();
        idle();
        we = 1'b1; wa = 5'd5; wd = 64'h55; rr1 = 5'd5;
        step();
        idle();
        push(0, K_RD1, 64'h55, "pre_reset_data");
        step();
        reset_n = 1'b0;
        we = 1'b1; wa = 5'd5; wd = 64'h77; re = 1'b1; ra = 5'd5; rr1 = 5'd5; rr2 = 5'd5;
        push(0, K_RD1, 64'h0, "reset_now_rd1");
        push(0, K_RD2, 64'h0, "reset_now_rd2");
        push(0, K_CNT, 64'h0, "reset_now_count");
        step();
        reset_n = 1'b1;
        idle();
        push(0, K_RD1, 64'h0, "after_reset_data");
        step();
    endtask

    initial begin
        reset_n = 1'b0;
        rr1 = '0; rr2 = '0; wa = '0; ra = '0; wd = '0;
        idle();
        model_reset();
        @(negedge clock);
        test_reset();
        test_bypass();
        test_zero_reg();
        test_reserve_write();
        test_same_cycle_flush();
        test_random();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised general-purpose register file for the CoreTech datapath.
- Provides two combinational read ports and one synchronous write port, with an optional hard-wired zero register and optional write-to-read bypass.
- Adds a per-register busy scoreboard so decode can detect pending multi-cycle results, such as loads, and stall.
- Sits between decode (reads, reservations) and writeback (writes).

Parameters:
- DATA_WIDTH, 32, width of each register in bits.
- ADDR_WIDTH, 4, register address width; depth NUM_REGS = 2**ADDR_WIDTH.
- ZERO_REG, 1, if 1 then register 0 always reads 0 and is never written or reserved.
- BYPASS, 1, if 1 then a read of the address being written this cycle returns write_data and reports not busy.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- read_register1  in  ADDR_WIDTH  read port 1 address.
- read_register2  in  ADDR_WIDTH  read port 2 address.
- read_data1  out  DATA_WIDTH  port 1 data, combinational.
- read_data2  out  DATA_WIDTH  port 2 data, combinational.
- read_busy1  out  1  port 1 register has a pending reserved write.
- read_busy2  out  1  port 2 register has a pending reserved write.
- reg_write  in  1  write enable.
- write_register  in  ADDR_WIDTH  write address.
- write_data  in  DATA_WIDTH  write data.
- reserve_en  in  1  mark reserve_register busy, i.e. a result is in flight.
- reserve_register  in  ADDR_WIDTH  register to reserve.
- flush  in  1  synchronous clear of all busy bits (pipeline squash); data is untouched.
- busy_count  out  ADDR_WIDTH+1  number of busy registers, registered.

Behaviour:
- Reset (reset_n=0, asynchronous assert, synchronous-to-clock release):
  - All NUM_REGS registers cleared to 0; all busy bits cleared; busy_count=0.
  - While reset is held, read_data1/2=0 and read_busy1/2=0 for every address.
- Reads: purely combinational, zero latency. read_dataN = regs[read_registerN], except for the overrides below.
- Zero register (ZERO_REG=1), address 0:
  - read_dataN=0 and read_busyN=0.
  - Writes to address 0 are dropped; reserves of address 0 are dropped.
- Write: on a rising edge with reg_write=1 and the address writable, regs[write_register] <= write_data. The new value is visible to reads in the following cycle.
- Bypass (BYPASS=1): if reg_write=1, write_register==read_registerN, and the address is writable:
  - read_dataN=write_data and read_busyN=0 in the same cycle.
  - The zero-register rule overrides bypass.
- Bypass off (BYPASS=0): reads return the old value and the old busy state until the next cycle.
- Busy bits, per register, updated each rising edge in priority order:
  - flush=1: all bits <= 0; write and reserve in the same cycle do not affect busy. The write itself still updates the data.
  - Otherwise, a write clears busy[write_register] and a reserve sets busy[reserve_register].
  - Same address written and reserved in the same cycle: the bit ends set, because the new reservation belongs to a later result.
  - Write to a non-busy register: data updated, busy stays 0, which is legal.
  - Reserve of an already-busy register: stays 1; there is no counting.
- busy_count: registered popcount of the busy vector after the update. Range 0..NUM_REGS (or NUM_REGS-1 when ZERO_REG=1).
- Both read ports may address the same register; each port is independent.
- Reset asserted mid-operation overrides everything immediately, including any in-flight write in that cycle.
- No X on outputs after reset for any legal input combination.

Decomposition:
- Package regfile_pkg holds:
  - DEFAULT_DATA_WIDTH=32 and DEFAULT_ADDR_WIDTH=4.
  - ZERO_ADDR constant.
  - A function is_writable(addr, zero_reg), shared by the data and busy logic.
- One sub-module, regfile_scoreboard:
  - Owns the busy vector, the flush/write/reserve priority, and busy_count.
  - Exposes a busy vector output; the top indexes it per read port and applies the bypass and zero overrides.
- The data array stays in the top module.

Test Plan:
- Reset then read all addresses -> read_data=0, read_busy=0, busy_count=0. Assert reset_n=0 mid-run after writing reg 5 -> reg 5 reads 0 immediately.
- Write 0xDEADBEEF to reg 3 with read_register1=3 in the same cycle -> BYPASS=1: read_data1=0xDEADBEEF that cycle. BYPASS=0: old value that cycle, 0xDEADBEEF next cycle.
- ZERO_REG=1: write 0x1234 and reserve reg 0 -> read_data=0, read_busy=0, busy_count unchanged. ZERO_REG=0 with the same stimulus -> reads 0x1234, busy set.
- Reserve reg 7 -> next cycle read_busy1=1, busy_count=1. Write reg 7 with 0xA5 -> next cycle busy=0, data 0xA5, busy_count=0.
- Same cycle: write and reserve reg 9 -> busy[9]=1 and data updated. Reserve regs 1,2,4 then flush together with a reserve of reg 6 -> all busy=0, busy_count=0.
- Randomised reserve/write/flush streams checked against a reference model for data, busy bits, and busy_count at parameter sets (32,4,1,1), (16,3,0,0), and (64,5,1,0).
